// File: rtl/load_req_encoder.sv
// load_req_encoder
// Encodes per-register write requests into a binary destination index.
// A round-robin arbiter picks one requester, presents its index with a
// valid/ready handshake, and returns a one-hot grant on acceptance.
// Multi-request arbitrations are flagged and counted (saturating).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no pending request; arbitrate whenever any req bit is set
// HOLD    | dest_reg/dest_valid held until dest_valid & dest_ready

module load_req_encoder #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [(1<<IDX_W)-1:0]   req,
    output logic [IDX_W-1:0]        dest_reg,
    output logic                    dest_valid,
    input  logic                    dest_ready,
    output logic [(1<<IDX_W)-1:0]   grant,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam int NUM_REQ = 1 << IDX_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] dest_reg_q, dest_reg_d;
    logic             dest_valid_q, dest_valid_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             multi_req;
    logic             handshake;

    // Round-robin search: start one past the last winner and wrap around.
    // The index arithmetic wraps naturally because it is IDX_W bits wide.
    always_comb begin
        logic [IDX_W-1:0] idx_c;
        win_idx   = '0;
        win_found = 1'b0;
        idx_c     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_c = last_q + IDX_W'(k);
            if (!win_found && req[idx_c]) begin
                win_idx   = idx_c;
                win_found = 1'b1;
            end
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something.
    always_comb begin
        multi_req = |(req & (req - NUM_REQ'(1)));
    end

    assign handshake = dest_valid_q & dest_ready;

    // One-hot grant to the held index, only in the accepting cycle.
    always_comb begin
        grant = '0;
        if (handshake) begin
            grant[dest_reg_q] = 1'b1;
        end
    end

    // Next-state logic for the arbitration/hold FSM and conflict tracking.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        dest_reg_d     = dest_reg_q;
        dest_valid_d   = dest_valid_q;
        conflict_d     = 1'b0;
        conflict_cnt_d = conflict_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    dest_reg_d   = win_idx;
                    dest_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                    conflict_d   = multi_req;
                    if (multi_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
                        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // req is deliberately ignored here: a withdrawn request
                // still completes once the write path accepts it.
                if (handshake) begin
                    last_d       = dest_reg_q;
                    dest_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                dest_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; the pointer resets to NUM_REQ-1 so index 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            last_q         <= {IDX_W{1'b1}};
            dest_reg_q     <= '0;
            dest_valid_q   <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            dest_reg_q     <= dest_reg_d;
            dest_valid_q   <= dest_valid_d;
            conflict_q     <= conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign dest_reg     = dest_reg_q;
    assign dest_valid   = dest_valid_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_load_req_encoder.sv
// Testbench for load_req_encoder: directed scenarios plus a randomized
// run compared against a transaction-level reference model.

module tb_load_req_encoder;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] req;
    logic         dest_ready;

    logic [1:0]   dest_reg,     s_dest_reg;
    logic         dest_valid,   s_dest_valid;
    logic [N-1:0] grant,        s_grant;
    logic         conflict,     s_conflict;
    logic [7:0]   conflict_cnt;
    logic [1:0]   s_conflict_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit      m_pend;
    int      m_idx;
    int      m_last;
    bit      m_conf;
    int      m_cnt;

    load_req_encoder #(.IDX_W(2), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .dest_reg(dest_reg), .dest_valid(dest_valid), .dest_ready(dest_ready),
        .grant(grant), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    load_req_encoder #(.IDX_W(2), .CNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .req(req),
        .dest_reg(s_dest_reg), .dest_valid(s_dest_valid), .dest_ready(dest_ready),
        .grant(s_grant), .conflict(s_conflict), .conflict_cnt(s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        req        = '0;
        dest_ready = 1'b0;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req        = '0;
        dest_ready = 1'b0;
        reset_n    = 1'b0;
        #3;
        checks++;
        if (dest_valid !== 1'b0 || dest_reg !== 2'd0 || conflict !== 1'b0 ||
            conflict_cnt !== 8'd0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL reset: valid=%b reg=%0d conf=%b cnt=%0d grant=%b, want 0/0/0/0/0000",
                     dest_valid, dest_reg, conflict, conflict_cnt, grant);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; dest_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (dest_valid !== 1'b1 || dest_reg !== 2'd2 || grant !== 4'b0100 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL single: valid=%b reg=%0d grant=%b conf=%b, want 1/2/0100/0",
                     dest_valid, dest_reg, grant, conflict);
        end
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        checks++;
        if (dest_valid !== 1'b0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL single_done: valid=%b grant=%b, want 0/0000", dest_valid, grant);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111; dest_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (dest_valid !== 1'b1 || dest_reg !== 2'(exp_idx[i]) ||
                grant !== 4'(1 << exp_idx[i]) || conflict !== 1'b1 ||
                conflict_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL rr[%0d]: valid=%b reg=%0d grant=%b conf=%b cnt=%0d, want 1/%0d/%b/1/%0d",
                         i, dest_valid, dest_reg, grant, conflict, conflict_cnt,
                         exp_idx[i], 4'(1 << exp_idx[i]), i + 1);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (dest_valid !== 1'b0 || grant !== 4'b0 || conflict !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle[%0d]: valid=%b grant=%b conf=%b, want 0/0000/0",
                         i, dest_valid, grant, conflict);
            end
        end
        #1 req = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; dest_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (dest_valid !== 1'b1 || dest_reg !== 2'd1 || grant !== 4'b0) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b reg=%0d grant=%b, want 1/1/0000",
                         i, dest_valid, dest_reg, grant);
            end
            @(posedge clk);
        end
        #1 dest_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010 || dest_reg !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: grant=%b reg=%0d, want 0010/1", grant, dest_reg);
        end
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        checks++;
        if (dest_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: valid=%b, want 0", dest_valid);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b1000; dest_ready = 1'b0;
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        checks++;
        if (dest_valid !== 1'b1 || dest_reg !== 2'd3 || grant !== 4'b0) begin
            errors++;
            $display("FAIL withdraw_hold: valid=%b reg=%0d grant=%b, want 1/3/0000",
                     dest_valid, dest_reg, grant);
        end
        @(posedge clk); #1 dest_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL withdraw_grant: grant=%b, want 1000", grant);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (dest_valid !== 1'b0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL withdraw_done: valid=%b grant=%b, want 0/0000", dest_valid, grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0101; dest_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (dest_valid !== 1'b1 || conflict_cnt !== 8'd1 || dest_reg !== 2'd0) begin
            errors++;
            $display("FAIL areset_pre: valid=%b cnt=%0d reg=%0d, want 1/1/0",
                     dest_valid, conflict_cnt, dest_reg);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dest_valid !== 1'b0 || conflict_cnt !== 8'd0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL areset_now: valid=%b cnt=%0d grant=%b, want 0/0/0000",
                     dest_valid, conflict_cnt, grant);
        end
        req = '0; dest_ready = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dest_valid !== 1'b0 || grant !== 4'b0) begin
                errors++;
                $display("FAIL areset_after[%0d]: valid=%b grant=%b, want 0/0000",
                         i, dest_valid, grant);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req = 4'b1111; dest_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (s_conflict_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || s_conflict !== 1'b1 ||
                conflict_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL sat[%0d]: small_cnt=%0d small_conf=%b cnt=%0d, want %0d/1/%0d",
                         i, s_conflict_cnt, s_conflict, conflict_cnt,
                         (i + 1 > 3) ? 3 : i + 1, i + 1);
            end
            @(posedge clk);
        end
        #1 req = '0;
    endtask

    // Transaction-level model: one arbitration per idle edge, completion on accept.
    task automatic model_edge(input logic [N-1:0] r, input logic rdy);
        m_conf = 1'b0;
        if (!m_pend) begin
            if (r != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (r[(m_last + k) % N]) begin
                        m_idx = (m_last + k) % N;
                        break;
                    end
                end
                m_pend = 1'b1;
                m_conf = ($countones(r) >= 2);
                if (m_conf && m_cnt < 255) m_cnt++;
            end
        end else if (rdy) begin
            m_last = m_idx;
            m_pend = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_grant;
        do_reset();
        m_pend = 0; m_idx = 0; m_last = N - 1; m_conf = 0; m_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            model_edge(req, dest_ready);
            #1;
            req        = 4'($urandom_range(0, 15));
            dest_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_grant = (m_pend && dest_ready) ? 4'(1 << m_idx) : 4'b0;
            checks++;
            if (dest_valid !== m_pend || (m_pend && dest_reg !== 2'(m_idx)) ||
                grant !== exp_grant || conflict !== m_conf || conflict_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b reg=%0d grant=%b conf=%b cnt=%0d, want %b/%0d/%b/%b/%0d",
                         c, dest_valid, dest_reg, grant, conflict, conflict_cnt,
                         m_pend, m_idx, exp_grant, m_conf, m_cnt);
            end
        end
        #1 req = '0;
    endtask

    initial begin
        reset_n = 1'b0; req = '0; dest_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
